// File: rtl/sdram_cmdq_pkg.sv
// Shared types for the SDRAM command queue: FSM states, queued command layout
// and the wait-state timeout used when SDRAM_CMDQ_TIMEOUT_EN is defined.
package sdram_cmdq_pkg;

    // Queued entries are stored at these widths; narrower ports are zero-extended.
    localparam int CMDQ_ADDR_W_MAX = 32;
    localparam int CMDQ_DATA_W_MAX = 32;

    localparam int TIMEOUT_CYCLES = 255;
    localparam int TIMEOUT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DATA,
        ST_WAIT_FREE
    } cmdq_state_e;

    typedef struct packed {
        logic                       write;
        logic [CMDQ_ADDR_W_MAX-1:0] addr;
        logic [CMDQ_DATA_W_MAX-1:0] wdata;
    } cmd_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/level; pop frees space for a same-cycle
// push when full, and a push into an empty FIFO shows up one cycle later.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Host command queue in front of a single-command SDRAM controller, with an
// in-order read-return FIFO. Optional wait timeout: SDRAM_CMDQ_TIMEOUT_EN.
module sdram_cmd_queue
    import sdram_cmdq_pkg::*;
#(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int CMD_DEPTH  = 4,
    parameter int RD_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [DATA_WIDTH-1:0]       cmd_wdata,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [ADDR_WIDTH-1:0]       sd_addr,
    output logic                        sd_wr_enable,
    output logic [DATA_WIDTH-1:0]       sd_wr_data,
    output logic                        sd_rd_enable,
    input  logic [DATA_WIDTH-1:0]       sd_rd_data,
    input  logic                        sd_rd_ready,
    input  logic                        sd_busy,
    input  logic                        sd_ack,
    output logic [$clog2(CMD_DEPTH):0]  cmd_level,
    output logic                        idle
`ifdef SDRAM_CMDQ_TIMEOUT_EN
    ,
    output logic                        err
`endif
);

    localparam int ENTRY_W = $bits(cmd_entry_t);
    localparam int RD_LW   = $clog2(RD_DEPTH) + 1;

    cmdq_state_e            state_q, state_d;
    logic                   is_write_q;
    logic [ADDR_WIDTH-1:0]  sd_addr_q;
    logic [DATA_WIDTH-1:0]  sd_wr_data_q;

    cmd_entry_t             push_entry, head_entry;
    logic [ENTRY_W-1:0]     cmd_head_bits;
    logic                   cmd_full, cmd_empty, cmd_pop;
    logic                   rd_full, rd_empty, rd_push;
    logic [RD_LW-1:0]       rd_level;
    logic                   rd_outstanding, rd_room;
    logic                   unused_head_bits;

    always_comb begin
        push_entry       = '0;
        push_entry.write = cmd_write;
        push_entry.addr  = CMDQ_ADDR_W_MAX'(cmd_addr);
        push_entry.wdata = CMDQ_DATA_W_MAX'(cmd_wdata);
    end

    assign head_entry       = cmd_entry_t'(cmd_head_bits);
    assign unused_head_bits = ^{head_entry.addr, head_entry.wdata, rd_full};

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i (push_entry),
        .pop_i   (cmd_pop),
        .rdata_o (cmd_head_bits),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .level_o (cmd_level)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_push),
        .wdata_i (sd_rd_data),
        .pop_i   (rd_valid && rd_ready),
        .rdata_o (rd_data),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .level_o (rd_level)
    );

    // A read is only issued if its data is guaranteed a slot in the read FIFO.
    assign rd_outstanding = !is_write_q &&
                            (state_q == ST_ISSUE || state_q == ST_WAIT_ACK || state_q == ST_WAIT_DATA);
    assign rd_room        = (int'(rd_level) + int'(rd_outstanding)) < RD_DEPTH;

`ifdef SDRAM_CMDQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 err_q, err_d;
    assign err = err_q;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cmd_pop = 1'b0;
        rd_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty && !sd_busy && (head_entry.write || rd_room)) begin
                    cmd_pop = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (sd_ack) begin
                    if (is_write_q) begin
                        state_d = ST_WAIT_FREE;
                    end else if (sd_rd_ready) begin
                        rd_push = 1'b1;
                        state_d = ST_WAIT_FREE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (sd_rd_ready) begin
                    rd_push = 1'b1;
                    state_d = ST_WAIT_FREE;
                end
            end
            ST_WAIT_FREE: if (!sd_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

`ifdef SDRAM_CMDQ_TIMEOUT_EN
        tmo_cnt_d = '0;
        err_d     = err_q;
        if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DATA) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Only abandon the command if this cycle made no progress.
            if (state_d == state_q && tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_write_q   <= 1'b0;
            sd_addr_q    <= '0;
            sd_wr_data_q <= '0;
`ifdef SDRAM_CMDQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (cmd_pop) begin
                is_write_q   <= head_entry.write;
                sd_addr_q    <= head_entry.addr[ADDR_WIDTH-1:0];
                sd_wr_data_q <= head_entry.wdata[DATA_WIDTH-1:0];
            end
`ifdef SDRAM_CMDQ_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign cmd_ready    = !cmd_full;
    assign rd_valid     = !rd_empty;
    assign sd_addr      = sd_addr_q;
    assign sd_wr_data   = sd_wr_data_q;
    assign sd_wr_enable = is_write_q && (state_q == ST_ISSUE || state_q == ST_WAIT_ACK);
    assign sd_rd_enable = !is_write_q && (state_q == ST_ISSUE || state_q == ST_WAIT_ACK);
    assign idle         = (state_q == ST_IDLE) && cmd_empty && rd_empty;

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Directed bench for sdram_cmd_queue; the timeout scenario is built only when
// SDRAM_CMDQ_TIMEOUT_EN is defined.
module tb_sdram_cmd_queue;

    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_write, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sd_addr;
    logic          sd_wr_enable, sd_rd_enable;
    logic [DW-1:0] sd_wr_data, sd_rd_data;
    logic          sd_rd_ready, sd_busy, sd_ack;
    logic [2:0]    cmd_level;
    logic          idle;
`ifdef SDRAM_CMDQ_TIMEOUT_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_cmd_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .RD_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .sd_addr      (sd_addr),
        .sd_wr_enable (sd_wr_enable),
        .sd_wr_data   (sd_wr_data),
        .sd_rd_enable (sd_rd_enable),
        .sd_rd_data   (sd_rd_data),
        .sd_rd_ready  (sd_rd_ready),
        .sd_busy      (sd_busy),
        .sd_ack       (sd_ack),
        .cmd_level    (cmd_level),
        .idle         (idle)
`ifdef SDRAM_CMDQ_TIMEOUT_EN
        ,
        .err          (err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Controller model: ack each command while its enable is up, then return read data.
    task automatic serve(input string tag, input logic exp_wr, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] data);
        int n = 0;
        while (!(sd_wr_enable || sd_rd_enable) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_issued"}, sd_wr_enable | sd_rd_enable, 1);
        check({tag, "_kind"}, sd_wr_enable, exp_wr);
        check({tag, "_addr"}, sd_addr, exp_addr);
        if (exp_wr) check({tag, "_wdata"}, sd_wr_data, data);
        sd_ack = 1'b1;
        n = 0;
        while ((sd_wr_enable || sd_rd_enable) && n < 300) begin
            tick();
            n++;
        end
        sd_ack = 1'b0;
        if (!exp_wr) begin
            sd_rd_data  = data;
            sd_rd_ready = 1'b1;
            tick();
            sd_rd_ready = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 100) begin
            tick();
            n++;
        end
        check(tag, idle, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, sd_wr_enable, 0);
        check({tag, "_rd_en"}, sd_rd_enable, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_level"}, cmd_level, 0);
        check({tag, "_addr"}, sd_addr, 0);
        check({tag, "_wdata"}, sd_wr_data, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cycles, got, n;
        logic stable, rd_seen, seen;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rd_ready = 1'b0; sd_rd_data = '0; sd_rd_ready = 1'b0; sd_busy = 1'b0; sd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // Single write, acked in the fourth enable cycle.
        push_cmd(1'b1, AW'('h10), 8'hA5);
        en_cycles = 0; stable = 1'b1; rd_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sd_wr_enable) begin
                en_cycles++;
                if (sd_addr !== AW'('h10) || sd_wr_data !== 8'hA5) stable = 1'b0;
            end else if (en_cycles > 0) begin
                break;
            end
            if (sd_rd_enable) rd_seen = 1'b1;
            sd_ack = (en_cycles == 4);
            tick();
        end
        sd_ack = 1'b0;
        check("wr_en_cycles", en_cycles, 4);
        check("wr_stable", stable, 1);
        check("wr_no_rd_en", rd_seen, 0);
        wait_idle("wr_idle");

        // Five writes with the ack stuck low: one in flight, four queued.
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1;
            cmd_addr = AW'('h100 + i); cmd_wdata = DW'('h50 + i);
            check("q_ready", cmd_ready, 1);
            tick();
        end
        cmd_valid = 1'b0;
        check("q_full_ready", cmd_ready, 0);
        check("q_level", cmd_level, 4);
        repeat (5) tick();
        check("q_level_hold", cmd_level, 4);
        check("q_en_held", sd_wr_enable, 1);
        for (int i = 0; i < 5; i++) serve("q", 1'b1, AW'('h100 + i), DW'('h50 + i));
        wait_idle("q_idle");

        // Six reads with the host not draining: only four fit in the read FIFO.
        fork
            begin
                for (int i = 0; i < 6; i++) push_cmd(1'b0, AW'('h200 + i), '0);
            end
            begin
                for (int i = 0; i < 4; i++) serve("r", 1'b0, AW'('h200 + i), DW'('h11 + i));
            end
        join
        repeat (10) tick();
        check("r_hold_rd_en", sd_rd_enable, 0);
        check("r_hold_level", cmd_level, 2);
        check("r_hold_valid", rd_valid, 1);
        check("r_hold_head", rd_data, 8'h11);
        check("r_hold_idle", idle, 0);
        fork
            begin
                rd_ready = 1'b1; got = 0; n = 0;
                while (got < 6 && n < 400) begin
                    if (rd_valid) begin
                        check($sformatf("r_data%0d", got), rd_data, DW'('h11 + got));
                        got++;
                    end
                    tick();
                    n++;
                end
                rd_ready = 1'b0;
                check("r_count", got, 6);
            end
            begin
                for (int i = 4; i < 6; i++) serve("r2", 1'b0, AW'('h200 + i), DW'('h11 + i));
            end
        join
        wait_idle("r_idle");

        // Ack and read-ready in the same cycle.
        push_cmd(1'b0, AW'('h300), '0);
        n = 0;
        while (!sd_rd_enable && n < 50) begin
            tick();
            n++;
        end
        tick();
        sd_ack = 1'b1; sd_rd_ready = 1'b1; sd_rd_data = 8'h3C;
        check("co_rv_before", rd_valid, 0);
        tick();
        sd_ack = 1'b0; sd_rd_ready = 1'b0;
        check("co_rv", rd_valid, 1);
        check("co_data", rd_data, 8'h3C);
        check("co_rd_en_low", sd_rd_enable, 0);
        repeat (3) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("co_once", rd_valid, 0);
        wait_idle("co_idle");

        // Reset while waiting for read data, with another command queued.
        push_cmd(1'b0, AW'('h400), '0);
        n = 0;
        while (!sd_rd_enable && n < 50) begin
            tick();
            n++;
        end
        tick();
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        push_cmd(1'b1, AW'('h410), 8'h5A);
        check("mr_level", cmd_level, 1);
        rst_n = 1'b0;
        #3;
        check_reset_values("mr");
        tick();
        rst_n = 1'b1;
        sd_rd_ready = 1'b1; sd_rd_data = 8'h77; sd_ack = 1'b1;
        tick();
        tick();
        sd_rd_ready = 1'b0; sd_ack = 1'b0;
        check("mr_late_rv", rd_valid, 0);
        check("mr_late_idle", idle, 1);
        check("mr_late_level", cmd_level, 0);
        check("mr_late_wr_en", sd_wr_enable, 0);

`ifdef SDRAM_CMDQ_TIMEOUT_EN
        check("to_err0", err, 0);
        push_cmd(1'b1, AW'('h500), 8'h99);
        en_cycles = 0; seen = 1'b0; n = 0;
        while (n < 600) begin
            if (sd_wr_enable) begin
                en_cycles++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            tick();
            n++;
        end
        check("to_en_cycles", en_cycles, 256);
        check("to_err", err, 1);
        push_cmd(1'b1, AW'('h510), 8'h42);
        serve("to_next", 1'b1, AW'('h510), 8'h42);
        wait_idle("to_idle");
        check("to_err_sticky", err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
